// File: rtl/counter_display_mux_pkg.sv
// -----------------------------------------------------------------------------
// disp_pkg
// Shared definitions for the two-digit seven-segment display multiplexer:
//   - disp_state_t : slot sequencer states, in display order
//   - SEG_BLANK / AN_OFF : all-dark segment and anode patterns
//   - SEG_0 .. SEG_9     : active-low {g,f,e,d,c,b,a} digit patterns
// No ports (package).
// -----------------------------------------------------------------------------
package disp_pkg;

   typedef enum logic [1:0] {
      BLANK_ONES = 2'd0,
      SHOW_ONES  = 2'd1,
      BLANK_TENS = 2'd2,
      SHOW_TENS  = 2'd3
   } disp_state_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [1:0] AN_OFF    = 2'b11;
   localparam logic [1:0] AN_ONES   = 2'b10;   // an[0] low drives the ones digit
   localparam logic [1:0] AN_TENS   = 2'b01;   // an[1] low drives the tens digit

   localparam logic [6:0] SEG_0 = 7'h40;
   localparam logic [6:0] SEG_1 = 7'h79;
   localparam logic [6:0] SEG_2 = 7'h24;
   localparam logic [6:0] SEG_3 = 7'h30;
   localparam logic [6:0] SEG_4 = 7'h19;
   localparam logic [6:0] SEG_5 = 7'h12;
   localparam logic [6:0] SEG_6 = 7'h02;
   localparam logic [6:0] SEG_7 = 7'h78;
   localparam logic [6:0] SEG_8 = 7'h00;
   localparam logic [6:0] SEG_9 = 7'h10;

endpackage

// File: rtl/counter_display_mux_if.sv
// -----------------------------------------------------------------------------
// counter_display_mux_if
// Bundles the count input and the display-side outputs of counter_display_mux.
//   count_in   [3:0] : unsigned count from the upstream counter
//   seg        [6:0] : segment cathodes {g,f,e,d,c,b,a}, active-low
//   an         [1:0] : digit anodes, active-low; an[0]=ones, an[1]=tens
//   frame_tick       : one-cycle pulse at each frame boundary
// Modports:
//   master : upstream / board side (drives count_in, observes the display)
//   slave  : the display multiplexer itself
// -----------------------------------------------------------------------------
interface counter_display_mux_if;
   import disp_pkg::*;

   logic [3:0] count_in;
   logic [6:0] seg;
   logic [1:0] an;
   logic       frame_tick;

   modport master (
      output count_in,
      input  seg,
      input  an,
      input  frame_tick
   );

   modport slave (
      input  count_in,
      output seg,
      output an,
      output frame_tick
   );

endinterface

// File: rtl/counter_display_mux_bcd_to_seg7.sv
// -----------------------------------------------------------------------------
// bcd_to_seg7
// Combinational decimal digit to active-low seven-segment decoder.
//   i_digit [3:0] : digit value; 10..15 are not decimal digits and show dark
//   o_seg   [6:0] : {g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
module bcd_to_seg7
   import disp_pkg::*;
(
   input  logic [3:0] i_digit,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = SEG_BLANK;
      case (i_digit)
         4'd0:    o_seg = SEG_0;
         4'd1:    o_seg = SEG_1;
         4'd2:    o_seg = SEG_2;
         4'd3:    o_seg = SEG_3;
         4'd4:    o_seg = SEG_4;
         4'd5:    o_seg = SEG_5;
         4'd6:    o_seg = SEG_6;
         4'd7:    o_seg = SEG_7;
         4'd8:    o_seg = SEG_8;
         4'd9:    o_seg = SEG_9;
         default: o_seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/counter_display_mux.sv
// -----------------------------------------------------------------------------
// counter_display_mux
// Snapshots a 4-bit count once per refresh frame, splits it into tens/ones
// BCD digits and time-multiplexes them onto a 2-digit common-anode display.
// Each digit slot is REFRESH_DIV cycles: BLANK_CYCLES with all anodes off
// (anti-ghosting), then the digit is shown. A frame is two slots.
//
// Parameters:
//   REFRESH_DIV  : cycles per digit slot, blank + show (must exceed BLANK_CYCLES)
//   BLANK_CYCLES : dark cycles at the start of every slot (at least 1)
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : counter_display_mux_if.slave (count_in, seg, an, frame_tick)
// Build option:
//   COUNTER_DISPLAY_LZB_EN : when defined, a zero tens digit is left dark
//                            (leading-zero blanking); slot timing is unchanged.
// -----------------------------------------------------------------------------
module counter_display_mux
   import disp_pkg::*;
#(
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 4
)(
   input  logic                  clk,
   input  logic                  reset,
   counter_display_mux_if.slave  bus
);

   // div_cnt never exceeds REFRESH_DIV-BLANK_CYCLES-1, so this width suffices.
   localparam int DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [DIV_W-1:0] BLANK_LAST = DIV_W'(BLANK_CYCLES - 1);
   localparam logic [DIV_W-1:0] SHOW_LAST  = DIV_W'(REFRESH_DIV - BLANK_CYCLES - 1);

   disp_state_t      r_state;
   logic [DIV_W-1:0] r_div_cnt;
   logic [3:0]       r_snap;
   logic [6:0]       r_seg;
   logic [1:0]       r_an;
   logic             r_frame_tick;

   disp_state_t      w_state_next;
   logic [DIV_W-1:0] w_div_next;
   logic [6:0]       w_seg_next;
   logic [1:0]       w_an_next;
   logic             w_frame_tick_next;
   logic             w_slot_last;

   logic             w_snap_en;
   logic [3:0]       w_snap_eff;
   logic             w_tens;
   logic [3:0]       w_ones;
   logic [3:0]       w_digit     [2];
   logic [6:0]       w_digit_seg [2];

   // ------------------------------------------------------------------
   // Snapshot and BCD split
   // ------------------------------------------------------------------
   assign w_snap_en = (r_state == BLANK_ONES) && (r_div_cnt == '0);

   // The value being captured this cycle is forwarded so that a
   // one-cycle blank (BLANK_CYCLES=1) still decodes the fresh snapshot
   // on the edge that enters SHOW_ONES.
   assign w_snap_eff = w_snap_en ? bus.count_in : r_snap;

   assign w_tens = (w_snap_eff >= 4'd10);
   assign w_ones = w_tens ? (w_snap_eff - 4'd10) : w_snap_eff;

   assign w_digit[0] = w_ones;
   assign w_digit[1] = {3'b000, w_tens};

   // Index 0 decodes the ones digit, index 1 the tens digit.
   for (genvar gi = 0; gi < 2; gi++) begin : g_dec
      bcd_to_seg7 u_dec (
         .i_digit (w_digit[gi]),
         .o_seg   (w_digit_seg[gi])
      );
   end

   // ------------------------------------------------------------------
   // Slot sequencer: next state, prescaler and next outputs
   // ------------------------------------------------------------------
   always_comb begin
      w_state_next      = r_state;
      w_div_next        = r_div_cnt + DIV_W'(1);
      w_an_next         = AN_OFF;
      w_seg_next        = SEG_BLANK;
      w_frame_tick_next = 1'b0;
      w_slot_last       = 1'b0;

      case (r_state)
         BLANK_ONES, BLANK_TENS: w_slot_last = (r_div_cnt == BLANK_LAST);
         default:                w_slot_last = (r_div_cnt == SHOW_LAST);
      endcase

      if (w_slot_last) begin
         w_div_next = '0;
         case (r_state)
            BLANK_ONES: w_state_next = SHOW_ONES;
            SHOW_ONES:  w_state_next = BLANK_TENS;
            BLANK_TENS: w_state_next = SHOW_TENS;
            default:    w_state_next = BLANK_ONES;
         endcase
      end

      // Outputs follow the state being entered so anodes/segments move on
      // the same edge as the state register. Every SHOW is bracketed by a
      // BLANK, so the two anodes are never low together.
      case (w_state_next)
         SHOW_ONES: begin
            w_an_next  = AN_ONES;
            w_seg_next = w_digit_seg[0];
         end
         SHOW_TENS: begin
`ifdef COUNTER_DISPLAY_LZB_EN
            if (w_tens) begin
               w_an_next  = AN_TENS;
               w_seg_next = w_digit_seg[1];
            end
`else
            w_an_next  = AN_TENS;
            w_seg_next = w_digit_seg[1];
`endif
         end
         default: begin
            w_an_next  = AN_OFF;
            w_seg_next = SEG_BLANK;
         end
      endcase

      // BLANK_ONES with a zero prescaler is only ever reached by wrapping
      // from SHOW_TENS; the post-reset entry comes from the reset branch,
      // which holds the tick low.
      w_frame_tick_next = (w_state_next == BLANK_ONES) && (w_div_next == '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= BLANK_ONES;
         r_div_cnt    <= '0;
         r_snap       <= 4'd0;
         r_an         <= AN_OFF;
         r_seg        <= SEG_BLANK;
         r_frame_tick <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_div_cnt    <= w_div_next;
         r_an         <= w_an_next;
         r_seg        <= w_seg_next;
         r_frame_tick <= w_frame_tick_next;
         if (w_snap_en) begin
            r_snap <= bus.count_in;
         end
      end
   end

   assign bus.seg        = r_seg;
   assign bus.an         = r_an;
   assign bus.frame_tick = r_frame_tick;

endmodule
